// File: rtl/mips_mc_control.sv
// Multicycle MIPS control unit: Moore main FSM with an ALU function decoder.
// Optional bne support is compiled in when MIPS_MC_BNE_EN is defined.
module mips_mc_control #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic [2:0] ALU_Control,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       Halted,
  output logic [3:0] dbg_state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11,
    HALT   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

`ifdef MIPS_MC_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  localparam state_t ILLEGAL_NEXT = ILLEGAL_TRAP ? HALT : FETCH;

  state_t     state_q, state_d;
  logic       funct_ok;
  logic [2:0] funct_alu;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = 3'b010;
    case (Funct)
      6'b100000: funct_alu = 3'b010;
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      default:   funct_ok  = 1'b0;
    endcase
  end

  // Illegal opcodes/functs are caught in DECODE, before any write-enable state.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = funct_ok ? EXEC : ILLEGAL_NEXT;
          OP_BEQ:       state_d = BRANCH;
          OP_BNE:       state_d = BNE_EN ? BRANCH : ILLEGAL_NEXT;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = ILLEGAL_NEXT;
        endcase
      end
      MEMADR: state_d = (Op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  state_d = MEMWB;
      EXEC:   state_d = ALUWB;
      ADDIEX: state_d = ADDIWB;
      HALT:   state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  assign dbg_state = state_q;

  always_comb begin
    ALU_Control = 3'b010;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSrc       = 2'b00;
    PCEn        = 1'b0;
    IorD        = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    Halted      = 1'b0;
    case (state_q)
      FETCH: begin
        ALUSrcB = 2'b01;
        IRWrite = 1'b1;
        PCEn    = 1'b1;
      end
      DECODE: ALUSrcB = 2'b11;
      MEMADR, ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: IorD = 1'b1;
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      EXEC: begin
        ALUSrcA     = 1'b1;
        ALU_Control = funct_alu;
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      // Op is still held by the IR here, so it selects beq vs bne polarity.
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALU_Control = 3'b110;
        PCSrc       = 2'b01;
        PCEn        = (BNE_EN && (Op == OP_BNE)) ? ~Zero : Zero;
      end
      ADDIWB: RegWrite = 1'b1;
      JUMP: begin
        PCSrc = 2'b10;
        PCEn  = 1'b1;
      end
      HALT: Halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: one instance per ILLEGAL_TRAP setting,
// a per-cycle vector table plus hand sequences for reset, illegal and bne.
module tb_mips_mc_control;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_HALT   = 4'd12;

  // {alu[2:0], srca, srcb[1:0], pcsrc[1:0], pcen, iord, memwrite, irwrite,
  //  regdst, memtoreg, regwrite, halted}
  localparam logic [15:0] O_FETCH  = 16'b010_0_01_00_1_0_0_1_0_0_0_0;
  localparam logic [15:0] O_DECODE = 16'b010_0_11_00_0_0_0_0_0_0_0_0;
  localparam logic [15:0] O_MEMADR = 16'b010_1_10_00_0_0_0_0_0_0_0_0;
  localparam logic [15:0] O_MEMRD  = 16'b010_0_00_00_0_1_0_0_0_0_0_0;
  localparam logic [15:0] O_MEMWB  = 16'b010_0_00_00_0_0_0_0_0_1_1_0;
  localparam logic [15:0] O_MEMWR  = 16'b010_0_00_00_0_1_1_0_0_0_0_0;
  localparam logic [15:0] O_EX_ADD = 16'b010_1_00_00_0_0_0_0_0_0_0_0;
  localparam logic [15:0] O_EX_SUB = 16'b110_1_00_00_0_0_0_0_0_0_0_0;
  localparam logic [15:0] O_EX_AND = 16'b000_1_00_00_0_0_0_0_0_0_0_0;
  localparam logic [15:0] O_EX_OR  = 16'b001_1_00_00_0_0_0_0_0_0_0_0;
  localparam logic [15:0] O_EX_SLT = 16'b111_1_00_00_0_0_0_0_0_0_0_0;
  localparam logic [15:0] O_ALUWB  = 16'b010_0_00_00_0_0_0_0_1_0_1_0;
  localparam logic [15:0] O_BR_TK  = 16'b110_1_00_01_1_0_0_0_0_0_0_0;
  localparam logic [15:0] O_BR_NT  = 16'b110_1_00_01_0_0_0_0_0_0_0_0;
  localparam logic [15:0] O_ADDIEX = 16'b010_1_10_00_0_0_0_0_0_0_0_0;
  localparam logic [15:0] O_ADDIWB = 16'b010_0_00_00_0_0_0_0_0_0_1_0;
  localparam logic [15:0] O_JUMP   = 16'b010_0_00_10_1_0_0_0_0_0_0_0;
  localparam logic [15:0] O_HALT   = 16'b010_0_00_00_0_0_0_0_0_0_0_1;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J = 6'b000010, OP_BAD = 6'b111111;

  // clock/reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] op = 6'd0, funct = 6'd0;
  logic       zero = 1'b0;

  logic [2:0] alu0, alu1;
  logic       srca0, srca1, pcen0, pcen1, iord0, iord1, mw0, mw1, irw0, irw1;
  logic [1:0] srcb0, srcb1, pcsrc0, pcsrc1;
  logic       rd0, rd1, m2r0, m2r1, rw0, rw1, h0, h1;
  logic [3:0] st0, st1;
  logic [15:0] out0, out1;

  assign out0 = {alu0, srca0, srcb0, pcsrc0, pcen0, iord0, mw0, irw0, rd0, m2r0, rw0, h0};
  assign out1 = {alu1, srca1, srcb1, pcsrc1, pcen1, iord1, mw1, irw1, rd1, m2r1, rw1, h1};

  mips_mc_control #(.ILLEGAL_TRAP(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .Op(op), .Funct(funct), .Zero(zero),
    .ALU_Control(alu0), .ALUSrcA(srca0), .ALUSrcB(srcb0), .PCSrc(pcsrc0),
    .PCEn(pcen0), .IorD(iord0), .MemWrite(mw0), .IRWrite(irw0), .RegDst(rd0),
    .MemtoReg(m2r0), .RegWrite(rw0), .Halted(h0), .dbg_state(st0)
  );

  mips_mc_control #(.ILLEGAL_TRAP(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .Op(op), .Funct(funct), .Zero(zero),
    .ALU_Control(alu1), .ALUSrcA(srca1), .ALUSrcB(srcb1), .PCSrc(pcsrc1),
    .PCEn(pcen1), .IorD(iord1), .MemWrite(mw1), .IRWrite(irw1), .RegDst(rd1),
    .MemtoReg(m2r1), .RegWrite(rw1), .Halted(h1), .dbg_state(st1)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [3:0]  st;
    logic [15:0] out;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [5:0] o, input logic [5:0] f, input logic z,
                     input logic [3:0] s, input logic [15:0] e, input string n);
    vec_t v;
    v.op = o; v.funct = f; v.zero = z; v.st = s; v.out = e; v.name = n;
    vecs.push_back(v);
  endtask

  task automatic check(input int which, input string name,
                       input logic [3:0] es, input logic [15:0] eo);
    logic [3:0]  s;
    logic [15:0] o;
    s = (which == 0) ? st0 : st1;
    o = (which == 0) ? out0 : out1;
    checks++;
    if (s !== es) begin
      failures++;
      $display("FAIL %s dut%0d state: got %0d expected %0d", name, which, s, es);
    end
    checks++;
    if (o !== eo) begin
      failures++;
      $display("FAIL %s dut%0d outputs: got %b expected %b", name, which, o, eo);
    end
  endtask

  task automatic apply(input logic [5:0] o, input logic [5:0] f, input logic z);
    op = o; funct = f; zero = z;
    #1;
  endtask

  task automatic next_cyc();
    @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $finish;
  end

  initial begin
    // lw: 5 cycles, write only in MEMWB
    add(OP_LW, 6'd0, 1'b0, S_FETCH,  O_FETCH,  "lw_fetch");
    add(OP_LW, 6'd0, 1'b0, S_DECODE, O_DECODE, "lw_decode");
    add(OP_LW, 6'd0, 1'b0, S_MEMADR, O_MEMADR, "lw_memadr");
    add(OP_LW, 6'd0, 1'b0, S_MEMRD,  O_MEMRD,  "lw_memrd");
    add(OP_LW, 6'd0, 1'b0, S_MEMWB,  O_MEMWB,  "lw_memwb");
    add(OP_SW, 6'd0, 1'b0, S_FETCH,  O_FETCH,  "sw_fetch");
    add(OP_SW, 6'd0, 1'b0, S_DECODE, O_DECODE, "sw_decode");
    add(OP_SW, 6'd0, 1'b0, S_MEMADR, O_MEMADR, "sw_memadr");
    add(OP_SW, 6'd0, 1'b0, S_MEMWR,  O_MEMWR,  "sw_memwr");
    add(OP_R, 6'b101010, 1'b0, S_FETCH,  O_FETCH,  "slt_fetch");
    add(OP_R, 6'b101010, 1'b0, S_DECODE, O_DECODE, "slt_decode");
    add(OP_R, 6'b101010, 1'b0, S_EXEC,   O_EX_SLT, "slt_exec");
    add(OP_R, 6'b101010, 1'b0, S_ALUWB,  O_ALUWB,  "slt_aluwb");
    add(OP_R, 6'b100100, 1'b0, S_FETCH,  O_FETCH,  "and_fetch");
    add(OP_R, 6'b100100, 1'b0, S_DECODE, O_DECODE, "and_decode");
    add(OP_R, 6'b100100, 1'b0, S_EXEC,   O_EX_AND, "and_exec");
    add(OP_R, 6'b100100, 1'b0, S_ALUWB,  O_ALUWB,  "and_aluwb");
    add(OP_R, 6'b100000, 1'b0, S_FETCH,  O_FETCH,  "add_fetch");
    add(OP_R, 6'b100000, 1'b0, S_DECODE, O_DECODE, "add_decode");
    add(OP_R, 6'b100000, 1'b0, S_EXEC,   O_EX_ADD, "add_exec");
    add(OP_R, 6'b100000, 1'b0, S_ALUWB,  O_ALUWB,  "add_aluwb");
    add(OP_R, 6'b100010, 1'b0, S_FETCH,  O_FETCH,  "sub_fetch");
    add(OP_R, 6'b100010, 1'b0, S_DECODE, O_DECODE, "sub_decode");
    add(OP_R, 6'b100010, 1'b0, S_EXEC,   O_EX_SUB, "sub_exec");
    add(OP_R, 6'b100010, 1'b0, S_ALUWB,  O_ALUWB,  "sub_aluwb");
    add(OP_R, 6'b100101, 1'b0, S_FETCH,  O_FETCH,  "or_fetch");
    add(OP_R, 6'b100101, 1'b0, S_DECODE, O_DECODE, "or_decode");
    add(OP_R, 6'b100101, 1'b0, S_EXEC,   O_EX_OR,  "or_exec");
    add(OP_R, 6'b100101, 1'b0, S_ALUWB,  O_ALUWB,  "or_aluwb");
    add(OP_BEQ, 6'd0, 1'b1, S_FETCH,  O_FETCH,  "beq_tk_fetch");
    add(OP_BEQ, 6'd0, 1'b1, S_DECODE, O_DECODE, "beq_tk_decode");
    add(OP_BEQ, 6'd0, 1'b1, S_BRANCH, O_BR_TK,  "beq_tk_branch");
    add(OP_BEQ, 6'd0, 1'b0, S_FETCH,  O_FETCH,  "beq_nt_fetch");
    add(OP_BEQ, 6'd0, 1'b0, S_DECODE, O_DECODE, "beq_nt_decode");
    add(OP_BEQ, 6'd0, 1'b0, S_BRANCH, O_BR_NT,  "beq_nt_branch");
    add(OP_ADDI, 6'd0, 1'b0, S_FETCH,  O_FETCH,  "addi_fetch");
    add(OP_ADDI, 6'd0, 1'b0, S_DECODE, O_DECODE, "addi_decode");
    add(OP_ADDI, 6'd0, 1'b0, S_ADDIEX, O_ADDIEX, "addi_ex");
    add(OP_ADDI, 6'd0, 1'b0, S_ADDIWB, O_ADDIWB, "addi_wb");
    add(OP_J, 6'd0, 1'b0, S_FETCH,  O_FETCH,  "j_fetch");
    add(OP_J, 6'd0, 1'b0, S_DECODE, O_DECODE, "j_decode");
    add(OP_J, 6'd0, 1'b1, S_JUMP,   O_JUMP,   "j_jump");
    add(OP_R, 6'b100000, 1'b0, S_FETCH, O_FETCH, "end_fetch");

    // reset state, with clocks running underneath
    apply(OP_LW, 6'd0, 1'b0);
    repeat (2) next_cyc();
    #1;
    check(0, "reset", S_FETCH, O_FETCH);
    check(1, "reset", S_FETCH, O_FETCH);
    next_cyc();
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].op, vecs[i].funct, vecs[i].zero);
      check(0, vecs[i].name, vecs[i].st, vecs[i].out);
      check(1, vecs[i].name, vecs[i].st, vecs[i].out);
      next_cyc();
    end

    // illegal opcode: no-op return vs. trap to HALT
    apply(OP_BAD, 6'd0, 1'b0);
    check(0, "ill_decode", S_DECODE, O_DECODE);
    check(1, "ill_decode", S_DECODE, O_DECODE);
    next_cyc();
    apply(OP_BAD, 6'd0, 1'b0);
    check(0, "ill_return", S_FETCH, O_FETCH);
    check(1, "ill_halt", S_HALT, O_HALT);
    for (int i = 0; i < 12; i++) begin
      next_cyc();
      apply(OP_BAD, 6'd0, i[0]);
      check(1, "ill_halt_hold", S_HALT, O_HALT);
    end
    // R-type with unsupported funct is illegal as well
    #2 rst_n = 1'b0;
    #1;
    check(1, "halt_async_clear", S_FETCH, O_FETCH);
    next_cyc();
    rst_n = 1'b1;
    apply(OP_R, 6'b000111, 1'b0);
    next_cyc();
    apply(OP_R, 6'b000111, 1'b0);
    next_cyc();
    apply(OP_R, 6'b000111, 1'b0);
    check(0, "badfunct_return", S_FETCH, O_FETCH);
    check(1, "badfunct_halt", S_HALT, O_HALT);

    // async reset in MEMRD: FETCH without a clock edge
    #2 rst_n = 1'b0;
    next_cyc();
    rst_n = 1'b1;
    apply(OP_LW, 6'd0, 1'b0);
    repeat (3) next_cyc();
    apply(OP_LW, 6'd0, 1'b0);
    check(0, "rst_pre_memrd", S_MEMRD, O_MEMRD);
    #2 rst_n = 1'b0;
    #1;
    check(0, "rst_async_memrd", S_FETCH, O_FETCH);
    check(1, "rst_async_memrd", S_FETCH, O_FETCH);
    next_cyc();
    rst_n = 1'b1;
    next_cyc();
    apply(OP_LW, 6'd0, 1'b0);
    check(0, "rst_after_release", S_DECODE, O_DECODE);
    next_cyc();
    check(0, "rst_after_memadr", S_MEMADR, O_MEMADR);

    // bne with Zero = 0
    #2 rst_n = 1'b0;
    next_cyc();
    rst_n = 1'b1;
    apply(OP_BNE, 6'd0, 1'b0);
    check(0, "bne_fetch", S_FETCH, O_FETCH);
    next_cyc();
    apply(OP_BNE, 6'd0, 1'b0);
    check(0, "bne_decode", S_DECODE, O_DECODE);
    next_cyc();
    apply(OP_BNE, 6'd0, 1'b0);
`ifdef MIPS_MC_BNE_EN
    check(0, "bne_branch", S_BRANCH, O_BR_TK);
    check(1, "bne_branch", S_BRANCH, O_BR_TK);
    apply(OP_BNE, 6'd0, 1'b1);
    check(0, "bne_branch_z1", S_BRANCH, O_BR_NT);
`else
    check(0, "bne_illegal", S_FETCH, O_FETCH);
    check(1, "bne_illegal", S_HALT, O_HALT);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Multicycle MIPS control unit: main Moore FSM plus ALU decoder.
- It drives ALU_Control[2:0] into the ALU and consumes the ALU's zero flag for branch resolution.
- Sits between the instruction register (Op, Funct) and the datapath muxes and write enables.
- One instruction at a time; 3–5 cycles per instruction.

Parameters:
- ILLEGAL_TRAP, default 0: 0 = illegal opcode or unsupported funct returns to FETCH as a no-op; 1 = enters HALT until reset.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- Op  in  6  instruction opcode, bits 31:26
- Funct  in  6  R-type function field, bits 5:0
- Zero  in  1  ALU zero flag, result == 0
- ALU_Control  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 = register B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2
- PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- PCEn  out  1  PC write enable; PCWrite OR (Branch AND taken)
- IorD  out  1  0 = PC address, 1 = ALUOut address
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- RegDst  out  1  0 = rt, 1 = rd
- MemtoReg  out  1  0 = ALUOut, 1 = data register
- RegWrite  out  1  register file write
- Halted  out  1  high in HALT state

Behaviour:
- Moore FSM with a 4-bit state register. All outputs are a combinational function of state, except PCEn (uses Zero) and ALU_Control (uses Funct).
- rst_n low → state = FETCH immediately, asynchronously. Reset mid-instruction abandons the instruction with no further writes.
- Out of reset, outputs take FETCH values: IorD 0, ALUSrcA 0, ALUSrcB 01, ALU_Control 010, PCSrc 00, IRWrite 1, PCEn 1, all others 0, Halted 0.
- Any output not listed for a state is 0.
- States, their outputs and transitions:
  - FETCH: outputs as above. Next: DECODE.
  - DECODE: ALUSrcA 0, ALUSrcB 11, ADD (precomputes the branch target). Next, by Op:
    - 100011 / 101011 → MEMADR
    - 000000 → EXEC, only if Funct is supported; else illegal
    - 000100 → BRANCH
    - 001000 → ADDIEX
    - 000010 → JUMP
    - anything else → illegal
  - MEMADR: ALUSrcA 1, ALUSrcB 10, ADD. Next: MEMRD if Op = 100011, else MEMWR.
  - MEMRD: IorD 1. Next: MEMWB.
  - MEMWB: RegDst 0, MemtoReg 1, RegWrite 1. Next: FETCH.
  - MEMWR: IorD 1, MemWrite 1. Next: FETCH.
  - EXEC: ALUSrcA 1, ALUSrcB 00, funct-decoded operation. Next: ALUWB.
  - ALUWB: RegDst 1, MemtoReg 0, RegWrite 1. Next: FETCH.
  - BRANCH: ALUSrcA 1, ALUSrcB 00, SUB, PCSrc 01, PCEn = Zero. Next: FETCH.
  - ADDIEX: ALUSrcA 1, ALUSrcB 10, ADD. Next: ADDIWB.
  - ADDIWB: RegDst 0, MemtoReg 0, RegWrite 1. Next: FETCH.
  - JUMP: PCSrc 10, PCEn 1. Next: FETCH.
  - HALT: all enables 0, Halted 1. Stays in HALT until rst_n.
- Illegal handling: ILLEGAL_TRAP = 0 → FETCH; ILLEGAL_TRAP = 1 → HALT. No register or memory write occurs either way.
- Funct decode: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111. Any other Funct is illegal.
- ALU_Control in non-ALU states: 010.
- Cycle counts from FETCH to the next FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Unused state encodings → FETCH on the next edge.

Optional Feature:
- Macro MIPS_MC_BNE_EN.
- Defined: Op 000101 in DECODE → BRANCH. In BRANCH, PCEn = Zero for beq and ~Zero for bne; Op is held stable by the IR.
- Undefined: Op 000101 is illegal.

Test Plan:
- Reset mid-instruction: assert rst_n low while in MEMRD → state = FETCH with no clock edge; IRWrite = 1, PCEn = 1, ALU_Control = 010 after release.
- lw, Op 100011: state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; RegWrite = 1 and MemtoReg = 1 only in cycle 5; MemWrite never 1.
- R-type, Op 000000: in EXEC, Funct 101010 → ALU_Control = 111 and Funct 100100 → 000; then ALUWB with RegDst = 1 and RegWrite = 1.
- beq, Op 000100: Zero = 1 → PCEn = 1 with PCSrc = 01 in cycle 3; Zero = 0 → PCEn = 0; both return to FETCH.
- Illegal Op 111111: with ILLEGAL_TRAP = 0 → FETCH after DECODE, no RegWrite or MemWrite; with ILLEGAL_TRAP = 1 → Halted = 1 held for 10+ cycles, cleared by rst_n.
- Op 000101 with Zero = 0: with MIPS_MC_BNE_EN defined → PCEn = 1 in BRANCH; without it → treated as illegal.
